// File: rtl/oloca_error_monitor_if.sv
// Sample and report handshake bundle for the lower-part-OR adder error monitor.
// The master side offers samples and takes statistics; the slave side is the monitor.
interface oloca_error_monitor_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [N:0]       in_approx;
    logic             stat_valid;
    logic             stat_ready;
    logic [CNT_W-1:0] stat_count;
    logic [CNT_W-1:0] stat_err_count;
    logic [ACC_W-1:0] stat_sum_ed;
    logic [N:0]       stat_max_ed;

    modport master (
        output in_valid, in_a, in_b, in_approx, stat_ready,
        input  in_ready, stat_valid, stat_count, stat_err_count, stat_sum_ed, stat_max_ed
    );

    modport slave (
        input  in_valid, in_a, in_b, in_approx, stat_ready,
        output in_ready, stat_valid, stat_count, stat_err_count, stat_sum_ed, stat_max_ed
    );
endinterface

// File: rtl/oloca_error_monitor.sv
// Windowed error statistics for an approximate adder: 2-stage pipe (E1 error distance, E2 accumulate).
// Report is held on stat_valid until stat_ready; sample input stalls (in_ready=0) outside ACCUM.
module oloca_error_monitor #(
    parameter int N      = 8,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16,
    parameter int ACC_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    oloca_error_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

    localparam int SW = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;
    localparam logic [SW-1:0] SAT_MAX = {{(SW - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] acc_cnt;
    logic             e1_vld;
    logic             e1_nz;
    logic [N:0]       e1_ed;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] err_q;
    logic [ACC_W-1:0] sum_q;
    logic [N:0]       max_q;

    logic             clear;
    logic             accept;
    logic             last_accept;
    logic [N:0]       exact;
    logic [N:0]       ed;
    logic [SW-1:0]    sum_ext;

    // A start in REPORT is ignored, so it must not wipe the pending report either.
    assign clear       = start && (state != REPORT);
    assign accept      = bus.in_valid && bus.in_ready && !start;
    assign last_accept = accept && (acc_cnt == CNT_W'(WINDOW - 1));

    assign exact   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign ed      = (exact >= bus.in_approx) ? (exact - bus.in_approx) : (bus.in_approx - exact);
    assign sum_ext = SW'(sum_q) + SW'(e1_ed);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (start) state_nxt = ACCUM;
                     else if (last_accept) state_nxt = DRAIN;
            DRAIN:   state_nxt = start ? ACCUM : REPORT;
            REPORT:  if (bus.stat_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready       = (state == ACCUM);
    assign bus.stat_valid     = (state == REPORT);
    assign busy               = (state == ACCUM) || (state == DRAIN);
    assign bus.stat_count     = count_q;
    assign bus.stat_err_count = err_q;
    assign bus.stat_sum_ed    = sum_q;
    assign bus.stat_max_ed    = max_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc_cnt <= '0;
            e1_vld  <= 1'b0;
            e1_nz   <= 1'b0;
            e1_ed   <= '0;
            count_q <= '0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                acc_cnt <= '0;
                e1_vld  <= 1'b0;
                count_q <= '0;
                err_q   <= '0;
                sum_q   <= '0;
                max_q   <= '0;
            end else begin
                e1_vld <= accept;
                if (accept) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                    e1_ed   <= ed;
                    e1_nz   <= (ed != '0);
                end
                if (e1_vld) begin
                    count_q <= count_q + CNT_W'(1);
                    err_q   <= err_q + CNT_W'(e1_nz);
                    sum_q   <= (sum_ext > SAT_MAX) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
                    if (e1_ed > max_q) max_q <= e1_ed;
                end
            end
        end
    end
endmodule

// File: tb/tb_oloca_error_monitor.sv
// Directed bench: two monitors (wide and 4-bit accumulator) share one stimulus stream.
module tb_oloca_error_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [8:0] in_approx = '0;
    logic       stat_ready = 1'b0;
    logic       busy0, busy1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    oloca_error_monitor_if #(.N(8), .CNT_W(16), .ACC_W(32)) b0 ();
    oloca_error_monitor_if #(.N(8), .CNT_W(16), .ACC_W(4))  b1 ();

    assign b0.in_valid   = in_valid;
    assign b0.in_a       = in_a;
    assign b0.in_b       = in_b;
    assign b0.in_approx  = in_approx;
    assign b0.stat_ready = stat_ready;
    assign b1.in_valid   = in_valid;
    assign b1.in_a       = in_a;
    assign b1.in_b       = in_b;
    assign b1.in_approx  = in_approx;
    assign b1.stat_ready = stat_ready;

    oloca_error_monitor #(.N(8), .WINDOW(4), .CNT_W(16), .ACC_W(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .bus(b0.slave)
    );
    oloca_error_monitor #(.N(8), .WINDOW(4), .CNT_W(16), .ACC_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .bus(b1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        tick();
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic take();
        stat_ready = 1'b1;
        tick();
        stat_ready = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input int cnt, input int err, input int sum,
                             input int mx, input int satsum);
        chk({tag, "_valid"},  b0.stat_valid,     1);
        chk({tag, "_count"},  b0.stat_count,     64'(cnt));
        chk({tag, "_err"},    b0.stat_err_count, 64'(err));
        chk({tag, "_sum"},    b0.stat_sum_ed,    64'(sum));
        chk({tag, "_max"},    b0.stat_max_ed,    64'(mx));
        chk({tag, "_satsum"}, b1.stat_sum_ed,    64'(satsum));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", b0.in_ready, 0);
        chk("rst_stat_valid", b0.stat_valid, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_count", b0.stat_count, 0);
        chk("rst_sum", b0.stat_sum_ed, 0);
        chk("rst_max", b0.stat_max_ed, 0);

        // Main window, back-to-back accepts with in_valid held
        pulse_start();
        chk("start_in_ready", b0.in_ready, 1);
        chk("start_busy", busy0, 1);
        put(8'h00, 8'h00, 9'h003);
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h13, 8'h21, 9'h033);
        chk("pre_last_in_ready", b0.in_ready, 1);
        put(8'h0C, 8'h0C, 9'h00F);
        // Offer a big-error sample during DRAIN; it must be ignored
        in_a = 8'h00; in_b = 8'h00; in_approx = 9'h1FF;
        chk("drain_in_ready", b0.in_ready, 0);
        chk("drain_busy", busy0, 1);
        chk("drain_stat_valid", b0.stat_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("report_busy", busy0, 0);
        chk_stats("main", 4, 4, 28, 15, 15);

        // Backpressure with a start pulse that must be ignored
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            tick();
            start = 1'b0;
            chk("bp_valid", b0.stat_valid, 1);
            chk("bp_count", b0.stat_count, 4);
            chk("bp_sum", b0.stat_sum_ed, 28);
            chk("bp_max", b0.stat_max_ed, 15);
        end
        take();
        chk("taken_valid", b0.stat_valid, 0);
        chk("taken_in_ready", b0.in_ready, 0);
        chk("taken_busy", busy0, 0);
        chk("taken_count_held", b0.stat_count, 4);
        tick();
        chk("idle_in_ready", b0.in_ready, 0);

        // Start during DRAIN aborts; the sample offered with start is dropped
        pulse_start();
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        start = 1'b1;
        in_valid = 1'b1; in_a = 8'h00; in_b = 8'h00; in_approx = 9'h0FF;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", b0.in_ready, 1);
        chk("abort_busy", busy0, 1);
        chk("abort_count", b0.stat_count, 0);
        chk("abort_sum", b0.stat_sum_ed, 0);
        tick();
        chk("abort_flight_count", b0.stat_count, 0);
        chk("abort_flight_max", b0.stat_max_ed, 0);
        put(8'h01, 8'h01, 9'h003);
        put(8'h00, 8'h00, 9'h000);
        put(8'h20, 8'h10, 9'h02F);
        put(8'h00, 8'h01, 9'h00F);
        in_valid = 1'b0;
        tick();
        chk_stats("post_abort", 4, 3, 16, 14, 15);
        take();

        // Saturation of the narrow accumulator
        pulse_start();
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        in_valid = 1'b0;
        tick();
        chk_stats("sat", 4, 4, 60, 15, 15);
        chk("sat_narrow_max", b1.stat_max_ed, 15);
        take();

        // Reset mid-ACCUM, then an exact-match window
        pulse_start();
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        put(8'h0F, 8'h0F, 9'h00F);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", b0.in_ready, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_valid", b0.stat_valid, 0);
        chk("midrst_count", b0.stat_count, 0);
        chk("midrst_sum", b0.stat_sum_ed, 0);
        pulse_start();
        put(8'h10, 8'h20, 9'h030);
        put(8'hFF, 8'hFF, 9'h1FE);
        put(8'h80, 8'h80, 9'h100);
        put(8'h01, 8'h02, 9'h003);
        in_valid = 1'b0;
        tick();
        chk_stats("exact", 4, 0, 0, 0, 0);
        take();
        chk("final_valid", b0.stat_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
